// File: rtl/fifo_pkg.sv
// Shared types and constants for the FIFO read-side stream adapter.
package fifo_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 8;
    localparam int unsigned BUF_DEPTH_MIN  = 2;

    typedef logic [DEF_DATA_WIDTH-1:0] fifo_word_t;

endpackage

// File: rtl/stream_buf.sv
// Circular skid buffer: captures FIFO read data at the tail, presents the head word.
module stream_buf
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned BUF_DEPTH  = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          capture,
    input  logic [DATA_WIDTH-1:0]         wdata,
    input  logic                          pop,
    output logic [DATA_WIDTH-1:0]         rdata,
    output logic [$clog2(BUF_DEPTH):0]    count
);

    localparam int unsigned PTR_W = $clog2(BUF_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
    logic [PTR_W-1:0]      head;
    logic [PTR_W-1:0]      tail;

    // Storage, pointers and occupancy; pointers wrap naturally since depth is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(BUF_DEPTH); i++) begin
                mem[i] <= '0;
            end
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (capture) begin
                mem[tail] <= wdata;
                tail      <= tail + PTR_W'(1);
            end
            if (pop) begin
                head <= head + PTR_W'(1);
            end
            count <= count + CNT_W'(capture) - CNT_W'(pop);
        end
    end

    // Head word is always presented; validity is decided by the caller from count.
    always_comb begin
        rdata = mem[head];
    end

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a registered-output FIFO into a valid/ready stream with a credit-limited read issue.
module fifo_stream_reader
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned BUF_DEPTH  = 2,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          fifo_empty,
    input  logic [DATA_WIDTH-1:0]         fifo_rdata,
    output logic                          fifo_rd_en,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [DATA_WIDTH-1:0]         m_data,
    output logic [$clog2(BUF_DEPTH):0]    buf_count,
    output logic [CNT_WIDTH-1:0]          xfer_count
);

    localparam int unsigned BCW   = $clog2(BUF_DEPTH) + 1;
    localparam int unsigned SUM_W = BCW + 1;

    logic             inflight;
    logic             pop;
    logic             issue;
    logic [SUM_W-1:0] occupied;
    logic [SUM_W-1:0] limit;

    // Read credit: buffered plus in-flight words must leave room, with a same-cycle pop
    // returning one slot. m_ready reaches fifo_rd_en combinationally by design.
    always_comb begin
        m_valid    = (buf_count != '0);
        pop        = m_valid && m_ready;
        occupied   = SUM_W'(buf_count) + SUM_W'(inflight);
        limit      = SUM_W'(BUF_DEPTH) + SUM_W'(pop);
        fifo_rd_en = !fifo_empty && (occupied < limit);
        issue      = fifo_rd_en && !fifo_empty;
    end

    // inflight marks fifo_rdata valid this cycle; xfer_count counts accepted words.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight   <= 1'b0;
            xfer_count <= '0;
        end else begin
            inflight <= issue;
            if (pop) begin
                xfer_count <= xfer_count + CNT_WIDTH'(1);
            end
        end
    end

    stream_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .BUF_DEPTH  (BUF_DEPTH)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .capture (inflight),
        .wdata   (fifo_rdata),
        .pop     (pop),
        .rdata   (m_data),
        .count   (buf_count)
    );

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: behavioural FIFO, word-order scoreboard and directed scenarios.
module tb_fifo_stream_reader;
    import fifo_pkg::*;

    localparam int BD  = 2;
    localparam int BCW = $clog2(BD) + 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             fifo_empty;
    fifo_word_t       fifo_rdata;
    logic             fifo_rd_en;
    logic             m_valid;
    logic             m_ready;
    fifo_word_t       m_data;
    logic [BCW-1:0]   buf_count;
    logic [15:0]      xfer_count;

    fifo_stream_reader dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_rdata (fifo_rdata),
        .fifo_rd_en (fifo_rd_en),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .buf_count  (buf_count),
        .xfer_count (xfer_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model state: upstream FIFO contents, words owed to the consumer, and handshake history.
    fifo_word_t  fifo_q[$];
    fifo_word_t  exp_q[$];
    fifo_word_t  pop_log[$];
    int          pop_cyc[$];
    int          exp_cnt, exp_infl, cyc, first_issue, first_valid, n_issue;
    logic [15:0] exp_xfer;
    logic        wr_en;
    fifo_word_t  wr_data;
    bit          pop_m, issue_m, exp_pop, exp_rd;

    // Behavioural upstream FIFO plus abstract occupancy: a read issued in one cycle
    // becomes a buffered word two edges later; each accepted word leaves in write order.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_q.delete();
            exp_q.delete();
            exp_cnt    = 0;
            exp_infl   = 0;
            exp_xfer   = '0;
            fifo_empty <= 1'b1;
            fifo_rdata <= '0;
        end else begin
            pop_m   = (exp_cnt != 0) && m_ready;
            issue_m = fifo_rd_en && !fifo_empty;
            if (pop_m) begin
                pop_log.push_back(exp_q.pop_front());
                pop_cyc.push_back(cyc);
                exp_xfer++;
            end
            if (issue_m) begin
                fifo_rdata <= fifo_q.pop_front();
                n_issue++;
                if (first_issue < 0) first_issue = cyc;
            end
            if (wr_en) begin
                fifo_q.push_back(wr_data);
                exp_q.push_back(wr_data);
            end
            fifo_empty <= (fifo_q.size() == 0);
            exp_cnt  = exp_cnt + exp_infl - int'(pop_m);
            exp_infl = int'(issue_m);
            cyc++;
        end
    end

    // Every-cycle comparison of all DUT outputs against the model.
    always @(negedge clk) begin
        if (!rst) begin
            exp_pop = (exp_cnt != 0) && m_ready;
            exp_rd  = !fifo_empty && (exp_cnt + exp_infl < BD + int'(exp_pop));
            check("fifo_rd_en", fifo_rd_en, exp_rd);
            check("m_valid", m_valid, exp_cnt != 0);
            check("buf_count", buf_count, exp_cnt);
            check("xfer_count", xfer_count, exp_xfer);
            if (exp_cnt != 0) check("m_data", m_data, exp_q[0]);
            if (m_valid && first_valid < 0) first_valid = cyc;
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        wr_en   = 1'b0;
        m_ready = 1'b0;
        #1;
        check("rst_m_valid", m_valid, 0);
        check("rst_buf_count", buf_count, 0);
        check("rst_xfer_count", xfer_count, 0);
        check("rst_m_data", m_data, 0);
        step(2);
        rst = 1'b0;
        pop_log.delete();
        pop_cyc.delete();
        first_issue = -1;
        first_valid = -1;
        n_issue     = 0;
        step(1);
    endtask

    task automatic write_word(input fifo_word_t w);
        wr_en   = 1'b1;
        wr_data = w;
        step(1);
        wr_en   = 1'b0;
    endtask

    task automatic wait_pops(input int n, input int budget);
        int k = 0;
        while (pop_log.size() < n && k < budget) begin
            step(1);
            k++;
        end
        check("drain_count", pop_log.size(), n);
    endtask

    fifo_word_t sent[$];
    int         mism;

    initial begin
        rst     = 1'b0;
        wr_en   = 1'b0;
        wr_data = '0;
        m_ready = 1'b0;
        cyc     = 0;
        #1;

        // Basic read with a always-ready consumer.
        do_reset();
        m_ready = 1'b1;
        write_word(8'h11);
        write_word(8'h22);
        write_word(8'h33);
        wait_pops(3, 20);
        step(2);
        if (pop_log.size() == 3) begin
            check("basic_w0", pop_log[0], 8'h11);
            check("basic_w1", pop_log[1], 8'h22);
            check("basic_w2", pop_log[2], 8'h33);
            check("basic_back_to_back", pop_cyc[2] - pop_cyc[0], 2);
        end
        check("basic_xfer", xfer_count, 3);
        check("basic_latency", first_valid, first_issue + 2);

        // Back-pressure: consumer stalled, buffer fills and reading stops.
        do_reset();
        for (int i = 1; i <= 8; i++) write_word(fifo_word_t'(i));
        step(10);
        check("bp_buf_count", buf_count, 2);
        check("bp_rd_en", fifo_rd_en, 0);
        check("bp_m_data", m_data, 8'h01);
        check("bp_issues", n_issue, 2);
        m_ready = 1'b1;
        wait_pops(8, 40);
        if (pop_log.size() == 8) begin
            for (int i = 0; i < 8; i++) check("bp_order", pop_log[i], i + 1);
            check("bp_no_gaps", pop_cyc[7] - pop_cyc[0], 7);
        end

        // Throughput: one write per cycle, consumer always ready.
        do_reset();
        m_ready = 1'b1;
        for (int i = 0; i < 20; i++) write_word(fifo_word_t'(i));
        wait_pops(20, 40);
        if (pop_log.size() == 20) begin
            check("tp_contiguous", pop_cyc[19] - pop_cyc[0], 19);
            check("tp_last", pop_log[19], 8'h13);
        end

        // Random consumer readiness against random data.
        do_reset();
        sent.delete();
        for (int i = 0; i < 100; i++) begin
            sent.push_back(fifo_word_t'($urandom_range(0, 255)));
            m_ready = 1'($urandom_range(0, 1));
            write_word(sent[i]);
        end
        begin
            int k = 0;
            while (pop_log.size() < 100 && k < 2000) begin
                m_ready = 1'($urandom_range(0, 1));
                step(1);
                k++;
            end
        end
        check("rand_count", pop_log.size(), 100);
        mism = 0;
        for (int i = 0; i < pop_log.size() && i < 100; i++) if (pop_log[i] != sent[i]) mism++;
        check("rand_order", mism, 0);
        check("rand_xfer", xfer_count, 100);

        // Single word with a toggling consumer.
        do_reset();
        write_word(8'hA5);
        for (int i = 0; i < 10; i++) begin
            m_ready = ~m_ready;
            step(1);
        end
        check("edge_pops", pop_log.size(), 1);
        if (pop_log.size() >= 1) check("edge_word", pop_log[0], 8'hA5);
        check("edge_m_valid", m_valid, 0);
        check("edge_rd_en", fifo_rd_en, 0);
        check("edge_inflight", dut.inflight, 0);

        // Reset in the middle of a stalled stream.
        do_reset();
        for (int i = 0; i < 5; i++) write_word(fifo_word_t'(8'h70 + i));
        step(4);
        check("mid_buf_count", buf_count, 2);
        do_reset();
        m_ready = 1'b1;
        write_word(8'h5A);
        write_word(8'h5B);
        wait_pops(2, 20);
        step(3);
        check("mid_pops", pop_log.size(), 2);
        if (pop_log.size() == 2) begin
            check("mid_w0", pop_log[0], 8'h5A);
            check("mid_w1", pop_log[1], 8'h5B);
        end
        check("mid_xfer", xfer_count, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
